// File: rtl/lock_io_pkg.sv
// Shared constants for the digital-lock input path: button indices and default divider settings.
package lock_io_pkg;

    localparam int BTN_ENTER    = 0;
    localparam int BTN_RST      = 1;
    localparam int BTN_CHANGE   = 2;
    localparam int BTN_CLEARDSP = 3;

    localparam int DEF_FAST_DIV_BITS = 17;
    localparam int DEF_SLOW_HALF     = 500000;
    localparam int DEF_DB_STAGES     = 3;
    localparam int DEF_N_BTN         = 4;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/db_channel.sv
// One debounced button: 2-flop synchroniser, strobe-driven shift register, level and rise pulse.
module db_channel
    import lock_io_pkg::*;
#(
    parameter int DB_STAGES = DEF_DB_STAGES
) (
    input  logic clk,
    input  logic clear,
    input  logic sample_en,
    input  logic btn_raw,
    output logic btn_db,
    output logic btn_rise
);

    logic                 sync1_q, sync1_d;
    logic                 sync2_q, sync2_d;
    logic [DB_STAGES-1:0] shift_q, shift_d;
    logic                 db_q, db_d;
    logic                 db_prev_q, db_prev_d;
    logic                 rise_q, rise_d;

    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        shift_d   = shift_q;
        db_d      = db_q;
        // Level only changes on a strobe and reflects the register contents after this shift.
        if (sample_en) begin
            shift_d = {shift_q[DB_STAGES-2:0], sync2_q};
            db_d    = &shift_d;
        end
        db_prev_d = db_q;
        rise_d    = db_q & ~db_prev_q;
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            shift_q   <= '0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            rise_q    <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            shift_q   <= shift_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            rise_q    <= rise_d;
        end
    end

    assign btn_db   = db_q;
    assign btn_rise = rise_q;

endmodule

// File: rtl/input_conditioner.sv
// Lock-board front end: fast scan divider, slow divider with sample strobe, and N debounced buttons.
module input_conditioner
    import lock_io_pkg::*;
#(
    parameter int FAST_DIV_BITS = DEF_FAST_DIV_BITS,
    parameter int SLOW_HALF     = DEF_SLOW_HALF,
    parameter int DB_STAGES     = DEF_DB_STAGES,
    parameter int N_BTN         = DEF_N_BTN
) (
    input  logic             clk,
    input  logic             clear,
    input  logic [N_BTN-1:0] btn_raw,
    output logic             clk_fast,
    output logic             clk_slow,
    output logic             sample_en,
    output logic [N_BTN-1:0] btn_db,
    output logic [N_BTN-1:0] btn_rise
);

    localparam int                SLOW_W    = cnt_width(SLOW_HALF);
    localparam logic [SLOW_W-1:0] SLOW_LAST = SLOW_W'(SLOW_HALF - 1);

    logic [FAST_DIV_BITS-1:0] fast_cnt_q, fast_cnt_d;
    logic                     clk_fast_q, clk_fast_d;
    logic [SLOW_W-1:0]        slow_cnt_q, slow_cnt_d;
    logic                     clk_slow_q, clk_slow_d;
    logic                     sample_en_q, sample_en_d;
    logic                     slow_wrap;

    always_comb begin
        fast_cnt_d = fast_cnt_q + FAST_DIV_BITS'(1);
        clk_fast_d = fast_cnt_d[FAST_DIV_BITS-1];

        slow_wrap  = (slow_cnt_q == SLOW_LAST);
        slow_cnt_d = slow_wrap ? '0 : slow_cnt_q + SLOW_W'(1);
        clk_slow_d = slow_wrap ? ~clk_slow_q : clk_slow_q;
        // Strobe coincides with the low-to-high toggle, so it marks one full slow period.
        sample_en_d = slow_wrap & ~clk_slow_q;
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            fast_cnt_q  <= '0;
            clk_fast_q  <= 1'b0;
            slow_cnt_q  <= '0;
            clk_slow_q  <= 1'b0;
            sample_en_q <= 1'b0;
        end else begin
            fast_cnt_q  <= fast_cnt_d;
            clk_fast_q  <= clk_fast_d;
            slow_cnt_q  <= slow_cnt_d;
            clk_slow_q  <= clk_slow_d;
            sample_en_q <= sample_en_d;
        end
    end

    assign clk_fast  = clk_fast_q;
    assign clk_slow  = clk_slow_q;
    assign sample_en = sample_en_q;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        db_channel #(
            .DB_STAGES(DB_STAGES)
        ) u_db (
            .clk      (clk),
            .clear    (clear),
            .sample_en(sample_en_q),
            .btn_raw  (btn_raw[i]),
            .btn_db   (btn_db[i]),
            .btn_rise (btn_rise[i])
        );
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with small dividers (period 8, strobe every 8 clk, 3 stages).
module tb_input_conditioner;

    logic       clk = 1'b0;
    logic       clear;
    logic [3:0] btn_raw;
    logic       clk_fast, clk_slow, sample_en;
    logic [3:0] btn_db, btn_rise;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rise_cnt [4];

    input_conditioner #(
        .FAST_DIV_BITS(3),
        .SLOW_HALF    (4),
        .DB_STAGES    (3),
        .N_BTN        (4)
    ) dut (
        .clk      (clk),
        .clear    (clear),
        .btn_raw  (btn_raw),
        .clk_fast (clk_fast),
        .clk_slow (clk_slow),
        .sample_en(sample_en),
        .btn_db   (btn_db),
        .btn_rise (btn_rise)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  raw;
        int          until_cyc;
        logic [3:0]  exp_db;
        logic [15:0] exp_rise;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One clock edge; samples 1 time unit later and tallies rise pulses.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 4; i++)
            if (btn_rise[i] === 1'b1) rise_cnt[i]++;
    endtask

    function automatic logic [15:0] rise_pack();
        return {rise_cnt[3][3:0], rise_cnt[2][3:0], rise_cnt[1][3:0], rise_cnt[0][3:0]};
    endfunction

    task automatic run_to(input int target);
        if (target <= cyc) begin
            checks++;
            errors++;
            $display("FAIL run_to target %0d not ahead of cyc %0d", target, cyc);
        end
        for (int n = 0; n < 1000 && cyc < target; n++) step();
    endtask

    initial begin
        for (int i = 0; i < 4; i++) rise_cnt[i] = 0;
        // edges counted from clear release; strobe-driven shifts happen at edges 5, 13, 21, ...
        vecs[0]  = '{4'b0001,  36, 4'b0000, 16'h0000};
        vecs[1]  = '{4'b0001,  37, 4'b0001, 16'h0000};
        vecs[2]  = '{4'b0001,  38, 4'b0001, 16'h0001};
        vecs[3]  = '{4'b0001,  48, 4'b0001, 16'h0001};
        vecs[4]  = '{4'b0101,  53, 4'b0001, 16'h0001};
        vecs[5]  = '{4'b0001,  80, 4'b0001, 16'h0001};
        vecs[6]  = '{4'b1001,  88, 4'b0001, 16'h0001};
        vecs[7]  = '{4'b0001,  96, 4'b0001, 16'h0001};
        vecs[8]  = '{4'b1001, 116, 4'b0001, 16'h0001};
        vecs[9]  = '{4'b1001, 117, 4'b1001, 16'h0001};
        vecs[10] = '{4'b1001, 124, 4'b1001, 16'h1001};
        vecs[11] = '{4'b1000, 132, 4'b1001, 16'h1001};
        vecs[12] = '{4'b1000, 133, 4'b1000, 16'h1001};
        vecs[13] = '{4'b1000, 140, 4'b1000, 16'h1001};
        vecs[14] = '{4'b1111, 170, 4'b1111, 16'h1112};

        clear   = 1'b1;
        btn_raw = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {19'd0, clk_fast, clk_slow, sample_en, btn_db, btn_rise}, 32'd0);

        @(negedge clk);
        clear   = 1'b0;
        btn_raw = 4'h0;
        cyc     = 0;

        for (int k = 1; k <= 16; k++) begin
            step();
            check("dividers", {29'd0, clk_fast, clk_slow, sample_en},
                  {29'd0, ((k % 8) >= 4), (((k / 4) % 2) == 1), ((k % 8) == 4)});
        end

        for (int v = 0; v < 15; v++) begin
            btn_raw = vecs[v].raw;
            run_to(vecs[v].until_cyc);
            check("btn_db", {28'd0, btn_db}, {28'd0, vecs[v].exp_db});
            check("rise_count", {16'd0, rise_pack()}, {16'd0, vecs[v].exp_rise});
        end

        // asynchronous clear mid-count with every button debounced high
        clear = 1'b1;
        #1;
        check("clear_immediate", {19'd0, clk_fast, clk_slow, sample_en, btn_db, btn_rise}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("clear_held", {19'd0, clk_fast, clk_slow, sample_en, btn_db, btn_rise}, 32'd0);
        @(negedge clk);
        clear = 1'b0;
        cyc   = 0;
        run_to(4);
        check("post_clear_strobe", {31'd0, sample_en}, 32'd1);
        run_to(20);
        check("post_clear_db_low", {28'd0, btn_db}, 32'd0);
        run_to(21);
        check("post_clear_db_high", {28'd0, btn_db}, 32'hF);
        run_to(22);
        check("post_clear_rise", {16'd0, rise_pack()}, {16'd0, 16'h2223});
        run_to(23);
        check("post_clear_rise_off", {28'd0, btn_rise}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
